// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divide/remainder unit: widths,
// operation and state encodings, and small decode helpers.
package div_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int STALLBUS_W = 6;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // DIV and REM interpret operands as two's complement.
  function automatic logic op_is_signed(div_op_e op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic op_is_rem(div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divide request/response bundle between the pipeline and div_unit.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                     div_start;
  div_op_e                  div_op;
  logic        [DATA_W-1:0] src1;
  logic        [DATA_W-1:0] src2;
  logic                     flush;
  logic                     stallreq_ex;
  logic        [DATA_W-1:0] result;
  logic                     result_valid;

  modport master (
    output div_start, div_op, src1, src2, flush,
    input  stallreq_ex, result, result_valid
  );

  modport slave (
    input  div_start, div_op, src1, src2, flush,
    output stallreq_ex, result, result_valid
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dvnd_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem_in < divisor always holds, so shifted < 2*divisor and the kept
  // remainder fits back into DATA_W bits.
  always_comb begin
    shifted = {rem_in, dvnd_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[DATA_W];
    rem_out = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU/REM/REMU unit: classifies the operation,
// iterates one quotient bit per cycle on magnitudes, then fixes up signs.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_e              state_q, state_d;
  logic       [CNT_W-1:0]  cnt_q, cnt_d;
  logic       [DATA_W-1:0] result_q, result_d;
  div_op_e                 op_q, op_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic       [DATA_W-1:0] dvnd_q, dvnd_d;
  logic       [DATA_W-1:0] dvsr_q, dvsr_d;
  logic       [DATA_W-1:0] rem_q, rem_d;

  logic                    sgn;
  logic                    src1_neg;
  logic                    src2_neg;
  logic       [DATA_W-1:0] mag1;
  logic       [DATA_W-1:0] mag2;
  logic                    div_zero;
  logic                    ovf;
  logic                    special;
  logic                    accept;
  logic       [DATA_W-1:0] step_rem;
  logic                    step_q;
  logic       [DATA_W-1:0] quo_next;
  logic       [DATA_W-1:0] quo_fix;
  logic       [DATA_W-1:0] rem_fix;

  // Operand decode and classification of the incoming instruction.
  always_comb begin
    sgn      = op_is_signed(bus.div_op);
    src1_neg = sgn & bus.src1[DATA_W-1];
    src2_neg = sgn & bus.src2[DATA_W-1];
    mag1     = src1_neg ? -bus.src1 : bus.src1;
    mag2     = src2_neg ? -bus.src2 : bus.src2;
    div_zero = (bus.src2 == '0);
    ovf      = sgn && (bus.src1 == 32'h8000_0000) && (bus.src2 == 32'hFFFF_FFFF);
    special  = div_zero | ovf;
    accept   = bus.div_start & ~bus.flush;
  end

  div_step u_step (
    .rem_in   (rem_q),
    .dvnd_bit (dvnd_q[DATA_W-1]),
    .divisor  (dvsr_q),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  // Final-iteration quotient/remainder with sign correction applied.
  always_comb begin
    quo_next = {dvnd_q[DATA_W-2:0], step_q};
    quo_fix  = neg_quo_q ? -quo_next : quo_next;
    rem_fix  = neg_rem_q ? -step_rem : step_rem;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = special ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Datapath next values: operand capture in IDLE, one step per BUSY cycle.
  always_comb begin
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvnd_d    = dvnd_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    result_d  = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = bus.div_op;
          neg_quo_d = src1_neg ^ src2_neg;
          neg_rem_d = src1_neg;
          dvnd_d    = mag1;
          dvsr_d    = mag2;
          rem_d     = '0;
          if (div_zero)
            result_d = op_is_rem(bus.div_op) ? bus.src1 : 32'hFFFF_FFFF;
          else if (ovf)
            result_d = op_is_rem(bus.div_op) ? 32'h0000_0000 : 32'h8000_0000;
        end
      end
      ST_BUSY: begin
        rem_d  = step_rem;
        dvnd_d = quo_next;
        if ((cnt_q == CNT_W'(DATA_W - 1)) && !bus.flush)
          result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
      end
      default: ;
    endcase
  end

  // Control state and the architecturally visible result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Iteration datapath registers; contents are don't-care until captured.
  always_ff @(posedge clk) begin
    op_q      <= op_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dvnd_q    <= dvnd_d;
    dvsr_q    <= dvsr_d;
    rem_q     <= rem_d;
  end

  assign bus.stallreq_ex  = ~rst & (((state_q == ST_IDLE) & bus.div_start & ~bus.flush)
                                    | (state_q == ST_BUSY));
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model plus a per-cycle
// checker for stallreq_ex, result_valid and result.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] val;
    int          issue;
    int          end_c;
    bit          killed;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model_result(div_op_e op, logic [31:0] a, logic [31:0] b);
    bit is_rem = (op == OP_REM) || (op == OP_REMU);
    bit sgn    = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Cycles from the request cycle to the result_valid cycle, inclusive.
  function automatic int model_latency(div_op_e op, logic [31:0] a, logic [31:0] b);
    bit sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Per-cycle compare against the outstanding-request queue.
  always @(negedge clk) begin
    logic exp_stall;
    logic exp_valid;
    exp_stall = 1'b0;
    exp_valid = 1'b0;
    if (q.size() > 0) begin
      if (cyc >= q[0].issue && cyc < q[0].end_c) exp_stall = 1'b1;
      if (cyc >= q[0].end_c) begin
        if (!q[0].killed) begin
          exp_valid = 1'b1;
          check("result", bus.result, q[0].val);
        end
        void'(q.pop_front());
      end
    end
    check("stallreq_ex", 32'(bus.stallreq_ex), 32'(exp_stall));
    check("result_valid", 32'(bus.result_valid), 32'(exp_valid));
  end

  task automatic run_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit keep, output logic [31:0] got, output int stalls,
                        output int vcyc);
    bit   seen;
    exp_t e;
    bus.div_op    = op;
    bus.src1      = a;
    bus.src2      = b;
    bus.div_start = 1'b1;
    e.val    = model_result(op, a, b);
    e.issue  = cyc;
    e.end_c  = cyc + model_latency(op, a, b) - 1;
    e.killed = 1'b0;
    q.push_back(e);
    stalls = 0;
    got    = '0;
    vcyc   = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.stallreq_ex) stalls++;
      if (bus.result_valid) begin
        seen = 1'b1;
        got  = bus.result;
        vcyc = cyc;
      end
    end
    if (!seen) begin
      failures++;
      $display("FAIL timeout op=%0d actual=no_result_valid required=result_valid", op);
    end
    @(posedge clk); #1;
    if (!keep) bus.div_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    int          st;
    int          v1;
    int          v2;
    exp_t        e;

    rst           = 1'b1;
    bus.div_start = 1'b0;
    bus.flush     = 1'b0;
    bus.div_op    = OP_DIV;
    bus.src1      = '0;
    bus.src2      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", bus.result, 32'h0);
    @(posedge clk); #1;

    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, got, st, v1);
    check("divu_100_7", got, 32'd14);
    check("divu_100_7_stalls", 32'(st), 32'd33);
    run_op(OP_REMU, 32'd100, 32'd7, 1'b0, got, st, v1);
    check("remu_100_7", got, 32'd2);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, got, st, v1);
    check("div_m7_2", got, 32'hFFFF_FFFD);
    check("div_m7_2_stalls", 32'(st), 32'd33);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, got, st, v1);
    check("rem_m7_2", got, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'd5, 32'd0, 1'b0, got, st, v1);
    check("div_5_0", got, 32'hFFFF_FFFF);
    check("div_5_0_stalls", 32'(st), 32'd1);
    run_op(OP_REM, 32'd5, 32'd0, 1'b0, got, st, v1);
    check("rem_5_0", got, 32'd5);
    check("rem_5_0_stalls", 32'(st), 32'd1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, got, st, v1);
    check("div_ovf", got, 32'h8000_0000);
    check("div_ovf_stalls", 32'(st), 32'd1);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, got, st, v1);
    check("rem_ovf", got, 32'h0);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, got, st, v1);
    check("divu_no_ovf", got, 32'h0);
    check("divu_no_ovf_stalls", 32'(st), 32'd33);
    run_op(OP_REMU, 32'd7, 32'd0, 1'b0, got, st, v1);
    check("remu_7_0", got, 32'd7);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, got, st, v1);
    check("div_7_m2", got, 32'hFFFF_FFFD);
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 1'b0, got, st, v1);
    check("rem_7_m2", got, 32'd1);
    run_op(OP_REM, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b0, got, st, v1);
    check("rem_m8_m3", got, 32'hFFFF_FFFE);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0, got, st, v1);
    check("divu_max_1", got, 32'hFFFF_FFFF);

    // Back-to-back: div_start stays high through DONE into the next IDLE.
    run_op(OP_DIVU, 32'd1000, 32'd10, 1'b1, got, st, v1);
    check("b2b_first", got, 32'd100);
    run_op(OP_DIVU, 32'd12345, 32'd100, 1'b0, got, st, v2);
    check("b2b_second", got, 32'd123);
    check("b2b_spacing", 32'(v2 - v1), 32'd34);

    // Reset at BUSY iteration 20.
    bus.div_op    = OP_DIVU;
    bus.src1      = 32'd5000;
    bus.src2      = 32'd7;
    bus.div_start = 1'b1;
    e.val = model_result(OP_DIVU, 32'd5000, 32'd7);
    e.issue = cyc; e.end_c = cyc + 33; e.killed = 1'b0;
    q.push_back(e);
    repeat (21) @(posedge clk);
    #1;
    q[0].killed   = 1'b1;
    q[0].end_c    = cyc;
    rst           = 1'b1;
    bus.div_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_result", bus.result, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, got, st, v1);
    check("after_rst", got, 32'd3);

    // Flush at BUSY iteration 10.
    bus.div_op    = OP_DIVU;
    bus.src1      = 32'd1000;
    bus.src2      = 32'd3;
    bus.div_start = 1'b1;
    e.val = model_result(OP_DIVU, 32'd1000, 32'd3);
    e.issue = cyc; e.end_c = cyc + 33; e.killed = 1'b0;
    q.push_back(e);
    repeat (11) @(posedge clk);
    #1;
    q[0].killed   = 1'b1;
    q[0].end_c    = cyc + 1;
    bus.flush     = 1'b1;
    bus.div_start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_stall", 32'(bus.stallreq_ex), 32'd0);
    check("flush_result_hold", bus.result, 32'd3);
    repeat (40) @(posedge clk);
    #1;

    // flush and rst both win over a simultaneous div_start in IDLE.
    bus.div_op    = OP_DIVU;
    bus.src1      = 32'd50;
    bus.src2      = 32'd5;
    bus.flush     = 1'b1;
    bus.div_start = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.div_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    run_op(OP_REMU, 32'd50, 32'd6, 1'b0, got, st, v1);
    check("final_remu", got, 32'd2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
